// File: rtl/axis_reg_slice_pipe.sv
// AXI-Stream register slice chain: wire, forward-registered or full skid-buffer stages with occupancy count.
// Optional tlast sideband enabled by defining AXIS_SLICE_TLAST_EN.
module axis_reg_slice_pipe #(
  parameter int DWIDTH = 32,
  parameter int STAGES = 1,
  parameter int MODE   = 2,
  localparam int OCC_W = $clog2(2*STAGES+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_in_tdata,
  input  logic              s_in_tvalid,
  output logic              s_in_tready,
`ifdef AXIS_SLICE_TLAST_EN
  input  logic              s_in_tlast,
  output logic              m_out_tlast,
`endif
  output logic [DWIDTH-1:0] m_out_tdata,
  output logic              m_out_tvalid,
  input  logic              m_out_tready,
  output logic [OCC_W-1:0]  occupancy
);

`ifdef AXIS_SLICE_TLAST_EN
  localparam int SW = DWIDTH + 1;
`else
  localparam int SW = DWIDTH;
`endif

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  logic [SW-1:0] in_word;
  logic [SW-1:0] out_word;
  logic          up_ready;

  // tlast rides as the top bit of the stored word so the skid copy carries it too
`ifdef AXIS_SLICE_TLAST_EN
  assign in_word     = {s_in_tlast, s_in_tdata};
  assign m_out_tdata = out_word[DWIDTH-1:0];
  assign m_out_tlast = out_word[DWIDTH];
`else
  assign in_word     = s_in_tdata;
  assign m_out_tdata = out_word;
`endif

  assign s_in_tready = up_ready & rst_n;

  generate
    if (MODE > 2 || MODE < 0 || STAGES < 1 || STAGES > 8) begin : g_bad_cfg
      $error("axis_reg_slice_pipe: illegal MODE or STAGES");
    end

    if (MODE == 0) begin : g_wire
      assign out_word     = in_word;
      assign m_out_tvalid = s_in_tvalid;
      assign up_ready     = m_out_tready;
      assign occupancy    = '0;
    end else begin : g_pipe
      logic          link_valid [0:STAGES];
      logic          link_ready [0:STAGES];
      logic [SW-1:0] link_data  [0:STAGES];
      logic [OCC_W-1:0] occ_reg;
      logic          s_xfer;
      logic          m_xfer;

      assign link_valid[0]      = s_in_tvalid;
      assign link_data[0]       = in_word;
      assign link_ready[STAGES] = m_out_tready;
      assign up_ready           = link_ready[0];
      assign m_out_tvalid       = link_valid[STAGES];
      assign out_word           = link_data[STAGES];

      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (MODE == 1) begin : g_fwd
          logic          v_reg;
          logic [SW-1:0] d_reg;

          assign link_ready[gi]   = link_ready[gi+1] | ~v_reg;
          assign link_valid[gi+1] = v_reg;
          assign link_data[gi+1]  = d_reg;

          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              v_reg <= 1'b0;
              d_reg <= '0;
            end else if (link_valid[gi] && link_ready[gi]) begin
              v_reg <= 1'b1;
              d_reg <= link_data[gi];
            end else if (link_ready[gi+1]) begin
              v_reg <= 1'b0;
            end
          end
        end else begin : g_full
          state_t        state_reg;
          logic          v_reg;
          logic          rdy_reg;
          logic [SW-1:0] main_reg;
          logic [SW-1:0] skid_reg;
          logic          in_x;
          logic          out_x;

          assign in_x             = link_valid[gi] & rdy_reg;
          assign out_x            = v_reg & link_ready[gi+1];
          assign link_ready[gi]   = rdy_reg;
          assign link_valid[gi+1] = v_reg;
          assign link_data[gi+1]  = main_reg;

          // rdy_reg resets low and rises on the first clock after release
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              state_reg <= EMPTY;
              v_reg     <= 1'b0;
              rdy_reg   <= 1'b0;
              main_reg  <= '0;
              skid_reg  <= '0;
            end else begin
              rdy_reg <= 1'b1;
              case (state_reg)
                EMPTY: begin
                  if (in_x) begin
                    main_reg  <= link_data[gi];
                    v_reg     <= 1'b1;
                    state_reg <= BUSY;
                  end
                end
                BUSY: begin
                  if (in_x && out_x) begin
                    main_reg <= link_data[gi];
                  end else if (in_x) begin
                    skid_reg  <= link_data[gi];
                    rdy_reg   <= 1'b0;
                    state_reg <= FULL;
                  end else if (out_x) begin
                    v_reg     <= 1'b0;
                    state_reg <= EMPTY;
                  end
                end
                FULL: begin
                  if (out_x) begin
                    main_reg  <= skid_reg;
                    state_reg <= BUSY;
                  end else begin
                    rdy_reg <= 1'b0;
                  end
                end
                default: begin
                  v_reg     <= 1'b0;
                  state_reg <= EMPTY;
                end
              endcase
            end
          end
        end
      end

      assign s_xfer    = s_in_tvalid & link_ready[0];
      assign m_xfer    = link_valid[STAGES] & m_out_tready;
      assign occupancy = occ_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          occ_reg <= '0;
        end else if (s_xfer && !m_xfer) begin
          occ_reg <= occ_reg + OCC_W'(1);
        end else if (!s_xfer && m_xfer) begin
          occ_reg <= occ_reg - OCC_W'(1);
        end
      end
    end
  endgenerate

endmodule
